// File: rtl/onehot_rr_arb_pkg.sv
// Shared types and helpers for the one-hot round-robin arbiter.
// Optional grant checker in the top is enabled by ONEHOT_RR_ARB_GRANT_CHECK_EN.
package onehot_rr_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_t;

    localparam int ARB_MAX_REQ = 32;

    // Binary index of the lowest set bit; 0 for an all-zero vector.
    function automatic int unsigned onehot2idx(input logic [ARB_MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = ARB_MAX_REQ - 1; i >= 0; i--) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request above ptr, wrapping to bit 0.
// Built as a double-width masked priority encoder.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_REQ-1:0]   pick_onehot,
    output logic [IDX_W-1:0]     pick_idx,
    output logic                 pick_vld
);

    logic [NUM_REQ-1:0]   w_mask;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [2*NUM_REQ-1:0] w_iso;
    int                   w_pos;

    // Lower half holds requests above ptr, upper half the full vector for the wrap.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_mask[i] = (i > int'(ptr));
        end
        w_dbl = {req, req & w_mask};
        w_iso = w_dbl & (~w_dbl + (2*NUM_REQ)'(1));
        w_pos = 0;
        for (int j = 2*NUM_REQ - 1; j >= 0; j--) begin
            if (w_dbl[j]) w_pos = j;
        end
    end

    assign pick_onehot = w_iso[2*NUM_REQ-1:NUM_REQ] | w_iso[NUM_REQ-1:0];
    assign pick_idx    = IDX_W'(w_pos % NUM_REQ);
    assign pick_vld    = |req;

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, 1-cycle turnaround gap and
// timeout preemption under contention. Macro ONEHOT_RR_ARB_GRANT_CHECK_EN adds a grant checker.
module onehot_rr_arbiter
    import onehot_rr_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        grant_vld,
    output logic [$clog2(NUM_REQ)-1:0]  grant_idx,
    output logic                        preempt,
    output logic                        grant_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]     r_grant_idx;
    logic [IDX_W-1:0]     w_grant_idx_nxt;
    logic                 r_grant_vld;
    logic                 r_preempt;
    logic                 w_preempt_nxt;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     w_ptr_nxt;
    logic [CNT_W-1:0]     r_hold_cnt;
    logic [CNT_W-1:0]     w_hold_nxt;

    logic [NUM_REQ-1:0]   w_pick_onehot;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_vld;
    logic                 w_owner_req;
    logic                 w_others_req;
    logic                 w_timeout;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req         (req),
        .ptr         (r_ptr),
        .pick_onehot (w_pick_onehot),
        .pick_idx    (w_pick_idx),
        .pick_vld    (w_pick_vld)
    );

    assign w_owner_req  = |(req & r_grant);
    assign w_others_req = |(req & ~r_grant);
    assign w_timeout    = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_grant_vld <= 1'b0;
            r_preempt   <= 1'b0;
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_grant_vld <= |w_grant_nxt;
            r_preempt   <= w_preempt_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE, ARB_GAP: w_state_nxt = w_pick_vld ? ARB_GRANT : ARB_IDLE;
            ARB_GRANT: begin
                if (!w_owner_req || (w_timeout && w_others_req)) w_state_nxt = ARB_GAP;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // A release wins over a simultaneous timeout, so preempt only fires while the owner still requests.
    always_comb begin
        w_grant_nxt     = r_grant;
        w_grant_idx_nxt = r_grant_idx;
        w_ptr_nxt       = r_ptr;
        w_hold_nxt      = r_hold_cnt;
        w_preempt_nxt   = 1'b0;
        case (r_state)
            ARB_IDLE, ARB_GAP: begin
                w_grant_nxt     = w_pick_vld ? w_pick_onehot : '0;
                w_grant_idx_nxt = w_pick_vld ? w_pick_idx : '0;
                w_hold_nxt      = '0;
            end
            ARB_GRANT: begin
                if (!w_owner_req || (w_timeout && w_others_req)) begin
                    w_grant_nxt     = '0;
                    w_grant_idx_nxt = '0;
                    w_ptr_nxt       = r_grant_idx;
                    w_hold_nxt      = '0;
                    w_preempt_nxt   = w_owner_req;
                end else if (!w_timeout) begin
                    w_hold_nxt = r_hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_grant_nxt     = '0;
                w_grant_idx_nxt = '0;
                w_hold_nxt      = '0;
            end
        endcase
    end

    assign grant     = r_grant;
    assign grant_vld = r_grant_vld;
    assign grant_idx = r_grant_idx;
    assign preempt   = r_preempt;

`ifdef ONEHOT_RR_ARB_GRANT_CHECK_EN
    logic r_grant_err;
    logic w_multi_hot;
    logic w_idx_bad;

    assign w_multi_hot = (r_grant & (r_grant - NUM_REQ'(1))) != '0;
    assign w_idx_bad   = r_grant_idx != IDX_W'(onehot2idx(ARB_MAX_REQ'(r_grant)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant_err <= 1'b0;
        end else if (w_multi_hot || w_idx_bad) begin
            r_grant_err <= 1'b1;
        end
    end

    assign grant_err = r_grant_err;
`else
    assign grant_err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed self-checking bench for onehot_rr_arbiter (NUM_REQ=4, MAX_HOLD=16).
module tb_onehot_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_vld;
    logic [1:0] grant_idx;
    logic       preempt;
    logic       grant_err;

    int checks = 0;
    int errors = 0;
    string phase = "";

    typedef struct {
        logic [3:0] grant;
        logic       preempt;
    } exp_t;

    exp_t sb[$];

    onehot_rr_arbiter #(
        .NUM_REQ  (4),
        .MAX_HOLD (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx),
        .preempt   (preempt),
        .grant_err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout in phase %s", phase);
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] oh_idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    // Drive req for one cycle, queue the output it should produce, then compare after the edge.
    task automatic cyc(input logic [3:0] r, input logic [3:0] eg, input logic ep);
        exp_t e;
        req = r;
        e.grant = eg;
        e.preempt = ep;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("grant", 32'(grant), 32'(e.grant));
        check("grant_vld", 32'(grant_vld), 32'(e.grant != 4'd0));
        check("grant_idx", 32'(grant_idx), 32'(oh_idx(e.grant)));
        check("preempt", 32'(preempt), 32'(e.preempt));
    endtask

    task automatic do_reset();
        req = 4'd0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        reset = 1'b1;
        req = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        phase = "reset";
        check("grant", 32'(grant), 32'h0);
        check("grant_vld", 32'(grant_vld), 32'h0);
        check("grant_idx", 32'(grant_idx), 32'h0);
        check("preempt", 32'(preempt), 32'h0);
        check("grant_err", 32'(grant_err), 32'h0);
        reset = 1'b0;

        phase = "basic";
        cyc(4'b0101, 4'b0001, 1'b0);
        cyc(4'b0100, 4'b0000, 1'b0);
        cyc(4'b0100, 4'b0100, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        phase = "rotate";
        do_reset();
        for (int k = 0; k < 4; k++) begin
            repeat (3) cyc(4'b1111, 4'(1 << k), 1'b0);
            cyc(4'b1111 & ~4'(1 << k), 4'b0000, 1'b0);
        end
        cyc(4'b1111, 4'b0001, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        phase = "preempt";
        do_reset();
        cyc(4'b0010, 4'b0010, 1'b0);
        for (int g = 1; g <= 15; g++) begin
            cyc((g >= 5) ? 4'b0110 : 4'b0010, 4'b0010, 1'b0);
        end
        cyc(4'b0110, 4'b0000, 1'b1);
        cyc(4'b0110, 4'b0100, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        phase = "solo";
        do_reset();
        cyc(4'b1000, 4'b1000, 1'b0);
        repeat (39) cyc(4'b1000, 4'b1000, 1'b0);
        check("hold_cnt", 32'(dut.r_hold_cnt), 32'd15);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        phase = "release_at_timeout";
        do_reset();
        cyc(4'b0011, 4'b0001, 1'b0);
        repeat (15) cyc(4'b0011, 4'b0001, 1'b0);
        cyc(4'b0010, 4'b0000, 1'b0);
        cyc(4'b0010, 4'b0010, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        phase = "async_reset";
        do_reset();
        cyc(4'b0100, 4'b0100, 1'b0);
        cyc(4'b0100, 4'b0100, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("grant", 32'(grant), 32'h0);
        check("grant_vld", 32'(grant_vld), 32'h0);
        check("grant_idx", 32'(grant_idx), 32'h0);
        check("ptr", 32'(dut.r_ptr), 32'd3);
        req = 4'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        phase = "grant_check";
`ifdef ONEHOT_RR_ARB_GRANT_CHECK_EN
        check("grant_err_clean", 32'(grant_err), 32'h0);
        force dut.r_grant = 4'b0110;
        @(posedge clk);
        #1;
        release dut.r_grant;
        check("grant_err_set", 32'(grant_err), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("grant_err_sticky", 32'(grant_err), 32'h1);
        check("grant_after_fault", 32'(grant), 32'h0);
        reset = 1'b1;
        #1;
        check("grant_err_cleared", 32'(grant_err), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
`else
        cyc(4'b1001, 4'b0001, 1'b0);
        check("grant_err_tied", 32'(grant_err), 32'h0);
        cyc(4'b0000, 4'b0000, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
